// File: rtl/reg_bank_wb_if.sv
// Write and dump handshake bundle for the write-back register bank.
// The master drives requests; the slave (the bank) answers.
interface reg_bank_wb_if #(
  parameter int NREG = 16,
  parameter int W    = 16
);
  logic [NREG-1:0]   en_reg;
  logic [W-1:0]      wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_err;
  logic [NREG*W-1:0] reg_group;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [3:0]        dump_idx;
  logic [W-1:0]      dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output en_reg, wr_data, wr_valid,
    output dump_start, dump_ready,
    input  wr_ready, wr_err, reg_group,
    input  dump_valid, dump_idx, dump_data,
    input  dump_busy, dump_done
  );

  modport slave (
    input  en_reg, wr_data, wr_valid,
    input  dump_start, dump_ready,
    output wr_ready, wr_err, reg_group,
    output dump_valid, dump_idx, dump_data,
    output dump_busy, dump_done
  );
endinterface

// File: rtl/reg_bank_wb.sv
// 16x16 write-back register bank with one-hot writes
// and a sequential debug dump that blocks writes while active.
module reg_bank_wb #(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_bank_wb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   regs_q [NREG];
  logic           wr_err_q;
  logic           done_q;

  logic           fire;
  logic           multi;
  logic           onehot;

  assign fire   = bus.wr_valid & (state_q == IDLE);
  // x & (x-1) clears the lowest set bit; non-zero means 2+ bits
  assign multi  = |(bus.en_reg & (bus.en_reg - 1'b1));
  assign onehot = (|bus.en_reg) & ~multi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      wr_err_q <= fire & multi;
      done_q   <= 1'b0;
      if (fire && onehot) begin
        for (int i = 0; i < NREG; i++)
          if (bus.en_reg[i])
            regs_q[i] <= bus.wr_data;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.dump_start) begin
            state_q <= DUMP;
            cnt_q   <= '0;
          end
        end
        DUMP: begin
          if (bus.dump_ready) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.reg_group = '0;
    for (int i = 0; i < NREG; i++)
      bus.reg_group[i*W +: W] = regs_q[i];
  end

  assign bus.wr_ready   = (state_q == IDLE);
  assign bus.wr_err     = wr_err_q;
  assign bus.dump_valid = (state_q == DUMP);
  assign bus.dump_busy  = (state_q != IDLE);
  assign bus.dump_done  = done_q;
  assign bus.dump_idx   = cnt_q;
  assign bus.dump_data  = (state_q == DUMP) ? regs_q[cnt_q] : '0;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: writes, rejects,
// dump sequencing, back-pressure and mid-dump reset.
module tb_reg_bank_wb;

  logic clk = 1'b0;
  logic rst_n;

  reg_bank_wb_if #(.NREG(16), .W(16)) bus ();

  reg_bank_wb #(.NREG(16), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic [15:0] mdl [16];

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      v[i*16 +: 16] = mdl[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] en,
                    input logic [15:0] d);
    bus.en_reg   = en;
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  int k;
  int lowc;

  initial begin
    rst_n          = 1'b0;
    bus.en_reg     = '0;
    bus.wr_data    = '0;
    bus.wr_valid   = 1'b0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_group", bus.reg_group, '0);
    chk("rst_err", bus.wr_err, 0);
    chk("rst_dvalid", bus.dump_valid, 0);
    chk("rst_ready", bus.wr_ready, 1);
    chk("rst_busy", bus.dump_busy, 0);

    wr(16'h0008, 16'hA5A5);
    mdl[3] = 16'hA5A5;
    chk("wr_r3", bus.reg_group, pack());
    chk("wr_r3_err", bus.wr_err, 0);

    wr(16'h0011, 16'hFFFF);
    chk("multi_group", bus.reg_group, pack());
    chk("multi_err1", bus.wr_err, 1);
    tick();
    chk("multi_err2", bus.wr_err, 0);

    wr(16'h0000, 16'h1234);
    chk("zero_group", bus.reg_group, pack());
    chk("zero_err", bus.wr_err, 0);

    for (int i = 0; i < 16; i++) begin
      wr(16'h1 << i, 16'h1000 + 16'(i));
      mdl[i] = 16'h1000 + 16'(i);
    end
    chk("load_group", bus.reg_group, pack());

    // zero-wait dump
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    lowc = 0;
    for (int i = 0; i < 16; i++) begin
      chk("zw_valid", bus.dump_valid, 1);
      chk("zw_idx", bus.dump_idx, i);
      chk("zw_data", bus.dump_data, 16'h1000 + 16'(i));
      if (!bus.wr_ready) lowc++;
      tick();
    end
    chk("zw_done", bus.dump_done, 1);
    chk("zw_dvalid0", bus.dump_valid, 0);
    chk("zw_busy", bus.dump_busy, 1);
    if (!bus.wr_ready) lowc++;
    tick();
    chk("zw_lowcnt", lowc, 17);
    chk("zw_ready_back", bus.wr_ready, 1);
    chk("zw_done_off", bus.dump_done, 0);

    // back-pressured dump with a write held pending
    bus.dump_ready = 1'b0;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    bus.en_reg     = 16'h0001;
    bus.wr_data    = 16'hDEAD;
    bus.wr_valid   = 1'b1;
    k = 0;
    for (int c = 0; c < 100 && k < 16; c++) begin
      bus.dump_ready = c[0];
      chk("bp_idx", bus.dump_idx, k);
      chk("bp_data", bus.dump_data, mdl[k]);
      chk("bp_wr_ready", bus.wr_ready, 0);
      tick();
      if (c[0]) k++;
    end
    chk("bp_count", k, 16);
    bus.wr_valid   = 1'b0;
    bus.dump_ready = 1'b0;
    chk("bp_done", bus.dump_done, 1);
    chk("bp_group", bus.reg_group, pack());
    tick();

    // write and dump_start in the same IDLE cycle
    bus.en_reg     = 16'h0001;
    bus.wr_data    = 16'hBEEF;
    bus.wr_valid   = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.wr_valid   = 1'b0;
    bus.dump_start = 1'b0;
    mdl[0] = 16'hBEEF;
    chk("same_idx", bus.dump_idx, 0);
    chk("same_data", bus.dump_data, 16'hBEEF);

    // reset at idx 7
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("r7_idx", bus.dump_idx, 7);
    chk("r7_data", bus.dump_data, 16'h1007);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    chk("r7_dvalid", bus.dump_valid, 0);
    chk("r7_group", bus.reg_group, '0);
    chk("r7_done", bus.dump_done, 0);
    chk("r7_busy", bus.dump_busy, 0);
    tick();
    chk("r7_done2", bus.dump_done, 0);

    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    chk("re_idx", bus.dump_idx, 0);
    chk("re_data", bus.dump_data, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("re_done", bus.dump_done, 1);
    bus.dump_ready = 1'b0;
    tick();
    chk("re_idle", bus.wr_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_wb.md
# reg_bank_wb

Write-back register bank that owns the 16 x 16-bit general registers and drives the packed `reg_group` bus read by the register mux. It accepts one-hot write enables with a data word over a valid/ready handshake and rejects malformed (multi-hot) enables. A debug dump sequencer streams R0..R15 out in order, and writes are held off while a dump runs.

## Interface
Parameters
- `NREG`, 16: number of registers. Fixed; the one-hot width and the `reg_group` width follow from it.
- `W`, 16: register width.

Ports
- `clk`  in  1: single clock; every register updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on `clk`.
- `en_reg`  in  16: one-hot write select; bit i targets Ri.
- `wr_data`  in  16: write data.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: bank can accept a write.
- `wr_err`  out  1: one-cycle pulse when a multi-hot write is rejected.
- `reg_group`  out  256: packed registers; Ri occupies bits [16i+15:16i].
- `dump_start`  in  1: request a full dump.
- `dump_valid`  out  1: dump word is presented.
- `dump_ready`  in  1: consumer takes the dump word.
- `dump_idx`  out  4: index of the register being presented.
- `dump_data`  out  16: value of R[`dump_idx`].
- `dump_busy`  out  1: dump sequencer is not IDLE.
- `dump_done`  out  1: one-cycle pulse after R15 is taken.

## Operation
- FSM states: IDLE, DUMP, DONE.
- Reset (`rst_n`=0 at a `clk` edge) sets:
  - all registers to 0, so `reg_group`=0;
  - state to IDLE and the dump counter to 0;
  - `wr_err`, `dump_done` and `dump_valid` to 0.
- Reset mid-dump abandons the dump without a `dump_done` pulse.
- `wr_ready` = (state==IDLE). It is a combinational function of state only and does not depend on `wr_valid`.
- A write fires when `wr_valid`&`wr_ready`. The fired write is classified by `en_reg`:
  - Exactly one bit set: Ri <= `wr_data`.
  - Zero bits set: accepted as a no-op, no register changes, no error.
  - Two or more bits set: accepted (the handshake completes), no register changes, `wr_err`=1 on the next cycle only.
- IDLE -> DUMP when `dump_start`=1. A write that fires in the same cycle is committed first and appears in the dump.
- DUMP:
  - Drive `dump_valid`=1, `dump_idx`=cnt, `dump_data`=R[cnt] (live value; no writes can occur during DUMP).
  - On `dump_ready`, cnt increments.
  - On `dump_ready` with cnt==15, cnt returns to 0 and the FSM goes to DONE.
- DONE lasts exactly one cycle with `dump_done`=1, `dump_valid`=0 and `wr_ready`=0, then goes to IDLE.
- `dump_start` outside IDLE is ignored; requests are not queued.
- `dump_busy`=1 in DUMP and DONE.
- `dump_idx` and `dump_data` are don't-care when `dump_valid`=0. The implementation drives them as R0/0 in IDLE.

## Timing
- Write latency: a write that fires at edge k is visible on `reg_group` after edge k. No bypass from `wr_data` to `reg_group`.
- `wr_err` is asserted in the cycle after the rejecting edge, for one cycle.
- `dump_start` sampled at edge k: `dump_valid`=1 from after edge k. R0 is taken at the first `dump_ready` edge.
- Zero-wait dump (`dump_ready` held high): 16 cycles of `dump_valid`, then 1 DONE cycle. `wr_ready` returns after 17 cycles.
- Back-pressure: `dump_ready`=0 holds `dump_idx` and `dump_data` stable. A stalled dump holds `wr_ready` low indefinitely.
- Writes may fire on consecutive cycles to the same or different registers. The last write wins.

## Test plan
- Reset, then write 0xA5A5 with `en_reg`=0x0008 -> `reg_group`[63:48]=0xA5A5 after the edge, all other fields 0, `wr_err`=0.
- `en_reg`=0x0011 with `wr_data`=0xFFFF -> handshake completes, `reg_group` unchanged, `wr_err` high for exactly one cycle. `en_reg`=0 -> no change, no error.
- Load Ri=0x1000+i, pulse `dump_start` with `dump_ready`=1 -> 16 words with idx 0..15 and data 0x1000..0x100F, then `dump_done` pulses once, `wr_ready` low for 17 cycles.
- During a dump, toggle `dump_ready` 1/0 and hold `wr_valid`=1 -> no word skipped or repeated, `wr_ready`=0 throughout, registers unchanged.
- Same cycle in IDLE: `wr_valid` with `en_reg`=0x0001 and `wr_data`=0xBEEF, plus `dump_start` -> the first dump word is idx 0, 0xBEEF.
- Assert `rst_n`=0 at idx 7 of a dump -> next cycle: IDLE, `dump_valid`=0, `reg_group`=0, no `dump_done`; a new dump afterwards starts at idx 0.
